// File: rtl/ppu_linebuf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ppu_defines (package)
// Brief   : Shared types and constants for the PPU scanline buffer.
// Revision: 1.0 - initial release
// ============================================================================
package ppu_defines;

    localparam int          LINE_W  = 256;
    localparam int          PIX_W   = 6;
    localparam int          PTR_W   = $clog2(LINE_W);
    localparam logic [5:0]  RST_PIX = 6'h0F;

    typedef enum logic [0:0] {
        LB_WR_FILL = 1'b0,
        LB_WR_FULL = 1'b1
    } linebuf_wr_states_t;

endpackage
`default_nettype wire

// File: rtl/ppu_linebuf_if.sv
`default_nettype none
// ============================================================================
// Module  : ppu_linebuf_if
// Brief   : PPU write side and VGA read side of the scanline buffer.
// Revision: 1.0 - initial release
// ============================================================================
interface ppu_linebuf_if #(
    parameter int PIX_W = 6
);
    logic             ppu_pix_wr;
    logic [PIX_W-1:0] ppu_pix;
    logic             ppu_line_start;
    logic             wr_full;
    logic             vga_line_end;
    logic [7:0]       vga_buf_idx;
    logic [PIX_W-1:0] vga_buf_out;
    logic             disp_bank;
    logic             ovf_err;
    logic             unf_err;
    logic             err_clr;

    // Driving side (PPU pipeline + VGA timing)
    modport master (
        output ppu_pix_wr, ppu_pix, ppu_line_start, vga_line_end,
               vga_buf_idx, err_clr,
        input  wr_full, vga_buf_out, disp_bank, ovf_err, unf_err
    );

    // The line buffer itself
    modport slave (
        input  ppu_pix_wr, ppu_pix, ppu_line_start, vga_line_end,
               vga_buf_idx, err_clr,
        output wr_full, vga_buf_out, disp_bank, ovf_err, unf_err
    );
endinterface
`default_nettype wire

// File: rtl/ppu_linebuf_bank.sv
`default_nettype none
// ============================================================================
// Module  : linebuf_bank
// Brief   : One scanline of pixels: sync write port, combinational read port.
// Revision: 1.0 - initial release
// ============================================================================
module linebuf_bank
    import ppu_defines::*;
#(
    parameter int             LINE_W  = ppu_defines::LINE_W,
    parameter int             PIX_W   = ppu_defines::PIX_W,
    parameter logic [PIX_W-1:0] RST_PIX = ppu_defines::RST_PIX,
    parameter int             PTR_W   = $clog2(LINE_W)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             we,
    input  wire logic [PTR_W-1:0] waddr,
    input  wire logic [PIX_W-1:0] wdata,
    input  wire logic [PTR_W-1:0] raddr,
    output logic      [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [LINE_W];

    // Storage: reset paints the whole line black, otherwise one write per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINE_W; i++) begin
                mem[i] <= RST_PIX;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/ppu_linebuf.sv
`default_nettype none
// ============================================================================
// Module  : ppu_linebuf
// Brief   : Ping-pong scanline buffer between PPU pixel pipe and VGA scan-out.
// Revision: 1.0 - initial release
// ============================================================================
module ppu_linebuf
    import ppu_defines::*;
#(
    parameter int               LINE_W      = ppu_defines::LINE_W,
    parameter int               PIX_W       = ppu_defines::PIX_W,
    parameter int               LINE_REPEAT = 2,
    parameter logic [PIX_W-1:0] RST_PIX     = ppu_defines::RST_PIX
) (
    input wire logic     clk,
    input wire logic     rst_n,
    ppu_linebuf_if.slave bus
);

    localparam int               PW       = $clog2(LINE_W);
    localparam logic [PW-1:0]    LAST_IDX = PW'(LINE_W - 1);
    localparam logic [1:0]       REP_LAST = 2'(LINE_REPEAT - 1);

    linebuf_wr_states_t state, state_n;
    logic [PW-1:0]      wr_ptr, wr_ptr_n;
    logic [1:0]         rep_cnt;
    logic               disp_bank;
    logic               ovf_err, unf_err;

    logic               wr_en;
    logic [PW-1:0]      wr_addr;
    logic               last_wr;
    logic               swap_pt;
    logic               do_swap;
    logic               drop;
    logic [PIX_W-1:0]   rd0, rd1;

    // A line_start with a write retargets that write to pixel 0
    assign wr_en   = (state == LB_WR_FILL) && bus.ppu_pix_wr;
    assign wr_addr = bus.ppu_line_start ? '0 : wr_ptr;
    assign last_wr = wr_en && (wr_addr == LAST_IDX);
    assign swap_pt = bus.vga_line_end && (rep_cnt == REP_LAST);
    assign do_swap = swap_pt && ((state == LB_WR_FULL) || last_wr);
    assign drop    = (state == LB_WR_FULL) && bus.ppu_pix_wr;

    // Write FSM next state: fill, park when full, restart on swap
    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        if (state == LB_WR_FILL) begin
            if (bus.ppu_pix_wr) begin
                wr_ptr_n = wr_addr + PW'(1);
                if (wr_addr == LAST_IDX) begin
                    state_n = LB_WR_FULL;
                end
            end else if (bus.ppu_line_start) begin
                wr_ptr_n = '0;
            end
        end
        if (do_swap) begin
            state_n  = LB_WR_FILL;
            wr_ptr_n = '0;
        end
    end

    // Write FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LB_WR_FILL;
            wr_ptr <= '0;
        end else begin
            state  <= state_n;
            wr_ptr <= wr_ptr_n;
        end
    end

    // Row repeat counter and display bank toggle at swap points
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt   <= '0;
            disp_bank <= 1'b0;
        end else begin
            if (bus.vga_line_end) begin
                rep_cnt <= (rep_cnt == REP_LAST) ? 2'd0 : rep_cnt + 2'd1;
            end
            if (do_swap) begin
                disp_bank <= ~disp_bank;
            end
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (drop)             ovf_err <= 1'b1;
            else if (bus.err_clr) ovf_err <= 1'b0;
            if (swap_pt && !do_swap) unf_err <= 1'b1;
            else if (bus.err_clr)    unf_err <= 1'b0;
        end
    end

    linebuf_bank #(.LINE_W(LINE_W), .PIX_W(PIX_W), .RST_PIX(RST_PIX)) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en && disp_bank),
        .waddr (wr_addr),
        .wdata (bus.ppu_pix),
        .raddr (bus.vga_buf_idx),
        .rdata (rd0)
    );

    linebuf_bank #(.LINE_W(LINE_W), .PIX_W(PIX_W), .RST_PIX(RST_PIX)) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en && !disp_bank),
        .waddr (wr_addr),
        .wdata (bus.ppu_pix),
        .raddr (bus.vga_buf_idx),
        .rdata (rd1)
    );

    assign bus.vga_buf_out = disp_bank ? rd1 : rd0;
    assign bus.disp_bank   = disp_bank;
    assign bus.wr_full     = (state == LB_WR_FULL);
    assign bus.ovf_err     = ovf_err;
    assign bus.unf_err     = unf_err;

endmodule
`default_nettype wire

// File: tb/tb_ppu_linebuf.sv
`default_nettype none
// ============================================================================
// Module  : tb_ppu_linebuf
// Brief   : Directed self-checking bench for ppu_linebuf.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ppu_linebuf;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ppu_linebuf_if #(.PIX_W(6)) bus ();

    ppu_linebuf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_n(input int n, input logic [5:0] val, input bit use_idx);
        for (int i = 0; i < n; i++) begin
            bus.ppu_pix_wr = 1'b1;
            bus.ppu_pix    = use_idx ? 6'(i) : val;
            step();
        end
        bus.ppu_pix_wr = 1'b0;
    endtask

    task automatic line_end();
        bus.vga_line_end = 1'b1;
        step();
        bus.vga_line_end = 1'b0;
    endtask

    task automatic rd(input string tag, input int idx, input logic [5:0] exp);
        bus.vga_buf_idx = 8'(idx);
        #1;
        chk(tag, 32'(bus.vga_buf_out), 32'(exp));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n              = 1'b0;
        bus.ppu_pix_wr     = 1'b0;
        bus.ppu_pix        = '0;
        bus.ppu_line_start = 1'b0;
        bus.vga_line_end   = 1'b0;
        bus.vga_buf_idx    = '0;
        bus.err_clr        = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // 1: reset state
        for (int i = 0; i < 256; i++) rd("rst_pix", i, 6'h0F);
        chk("rst_disp", 32'(bus.disp_bank), 0);
        chk("rst_full", 32'(bus.wr_full), 0);
        chk("rst_ovf",  32'(bus.ovf_err), 0);
        chk("rst_unf",  32'(bus.unf_err), 0);

        // 2: full line of index pattern, swap after two rows
        write_n(256, 6'h00, 1'b1);
        chk("t2_full", 32'(bus.wr_full), 1);
        line_end();
        chk("t2_disp_row1", 32'(bus.disp_bank), 0);
        rd("t2_old_pix", 37, 6'h0F);
        line_end();
        chk("t2_disp", 32'(bus.disp_bank), 1);
        rd("t2_pix37", 37, 6'h25);
        rd("t2_pix255", 255, 6'h3F);
        chk("t2_full_clr", 32'(bus.wr_full), 0);

        // 3: partial line discarded by line_start
        write_n(100, 6'h11, 1'b0);
        bus.ppu_line_start = 1'b1;
        step();
        bus.ppu_line_start = 1'b0;
        write_n(256, 6'h2A, 1'b0);
        chk("t3_full", 32'(bus.wr_full), 1);
        line_end();
        line_end();
        chk("t3_disp", 32'(bus.disp_bank), 0);
        for (int i = 0; i < 256; i++) rd("t3_pix", i, 6'h2A);
        chk("t3_ovf", 32'(bus.ovf_err), 0);
        chk("t3_unf", 32'(bus.unf_err), 0);

        // 4: underflow, then late completion swaps
        write_n(200, 6'h33, 1'b0);
        line_end();
        line_end();
        chk("t4_noswap", 32'(bus.disp_bank), 0);
        chk("t4_unf", 32'(bus.unf_err), 1);
        rd("t4_oldpix", 5, 6'h2A);
        write_n(56, 6'h33, 1'b0);
        chk("t4_full", 32'(bus.wr_full), 1);
        line_end();
        line_end();
        chk("t4_swap", 32'(bus.disp_bank), 1);
        rd("t4_pix0", 0, 6'h33);
        rd("t4_pix255", 255, 6'h33);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("t4_unf_clr", 32'(bus.unf_err), 0);

        // 5: overflow drops pixels; set beats clear
        write_n(256, 6'h05, 1'b0);
        chk("t5_ovf_pre", 32'(bus.ovf_err), 0);
        write_n(3, 6'h3C, 1'b0);
        chk("t5_ovf", 32'(bus.ovf_err), 1);
        line_end();
        line_end();
        chk("t5_disp", 32'(bus.disp_bank), 0);
        rd("t5_pix0", 0, 6'h05);
        rd("t5_pix255", 255, 6'h05);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("t5_ovf_clr", 32'(bus.ovf_err), 0);
        write_n(256, 6'h07, 1'b0);
        bus.ppu_pix_wr = 1'b1;
        bus.ppu_pix    = 6'h3C;
        bus.err_clr    = 1'b1;
        step();
        bus.ppu_pix_wr = 1'b0;
        bus.err_clr    = 1'b0;
        chk("t5_set_wins", 32'(bus.ovf_err), 1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("t5_ovf_clr2", 32'(bus.ovf_err), 0);
        line_end();
        line_end();
        chk("t5_disp2", 32'(bus.disp_bank), 1);
        rd("t5_pix10", 10, 6'h07);

        // 6: last pixel coincides with swapping line_end
        line_end();
        write_n(255, 6'h12, 1'b0);
        bus.ppu_pix_wr   = 1'b1;
        bus.ppu_pix      = 6'h3A;
        bus.vga_line_end = 1'b1;
        step();
        bus.ppu_pix_wr   = 1'b0;
        bus.vga_line_end = 1'b0;
        chk("t6_disp", 32'(bus.disp_bank), 0);
        rd("t6_pix255", 255, 6'h3A);
        rd("t6_pix254", 254, 6'h12);
        chk("t6_full", 32'(bus.wr_full), 0);
        chk("t6_unf", 32'(bus.unf_err), 0);

        // Mid-fill reset, with an underflow flag pending
        write_n(10, 6'h21, 1'b0);
        line_end();
        line_end();
        chk("t6_unf_set", 32'(bus.unf_err), 1);
        write_n(5, 6'h21, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_disp", 32'(bus.disp_bank), 0);
        chk("rst2_full", 32'(bus.wr_full), 0);
        chk("rst2_unf",  32'(bus.unf_err), 0);
        chk("rst2_ovf",  32'(bus.ovf_err), 0);
        rd("rst2_pix255", 255, 6'h0F);
        rd("rst2_pix100", 100, 6'h0F);
        step();
        rst_n = 1'b1;
        step();
        // Write pointer back at 0: a full line after reset must fill exactly
        write_n(255, 6'h01, 1'b0);
        chk("rst2_ptr_nf", 32'(bus.wr_full), 0);
        write_n(1, 6'h01, 1'b0);
        chk("rst2_ptr_full", 32'(bus.wr_full), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
